frame_tail_tx: RTL and testbench
================================

FRAME_TAIL_TX -- requirements
Module: frame_tail_tx

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; CRC field fully sent; the current bit boundary begins the CRC delimiter.
REQ-005 bitStart  input  1  one-cycle pulse at each nominal bit boundary.
REQ-006 samplePulse  input  1  sample-point pulse; 3 pulses per bit when rateSelector=1, 1 pulse per bit when rateSelector=0.
REQ-007 rateSelector  input  1  1 = 3-sample majority, 0 = single sample.
REQ-008 rxIn  input  1  bus level read back (1 recessive, 0 dominant).
REQ-009 txOut  output  1  registered bus drive (1 recessive, 0 dominant).
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 ackOk  output  1  one-cycle pulse: dominant ACK seen.
REQ-012 ackError  output  1  one-cycle pulse: ACK slot read recessive.
REQ-013 bitError  output  1  one-cycle pulse: dominant read in a delimiter or EOF bit.
REQ-014 overload  output  1  one-cycle pulse: dominant read in intermission bit 1 or 2.
REQ-015 tailDone  output  1  one-cycle pulse: intermission complete, bus available.

Function
REQ-016 States SHALL be IDLE, CRC_DEL, ACK_SLOT, ACK_DEL, EOF (bit counter 0-6), IFS (bit counter 0-2).
REQ-017 txOut SHALL be 1 in every state; the block never drives dominant.
REQ-018 Rationale for REQ-017: ACK is driven dominant by receivers, never by the transmitter.
REQ-019 IDLE + start -> CRC_DEL on the next edge; start outside IDLE SHALL be ignored.
REQ-020 Non-IDLE advance SHALL occur only on bitStart.
REQ-021 Advance order: CRC_DEL->ACK_SLOT->ACK_DEL->EOF0..EOF6->IFS0..IFS2->IDLE, 13 bits total.
REQ-022 Sample sequencer: sample count cleared on bitStart and on entry from IDLE.
REQ-023 rateSelector=1: samples 1-3 captured on successive samplePulses; bit value = majority of the 3.
REQ-024 rateSelector=0: bit value = the single sample.
REQ-025 The bit is evaluated in the cycle after the final sample; at most one evaluation per bit.
REQ-026 samplePulses beyond the required count within one bit SHALL be ignored.
REQ-027 bitStart arriving before evaluation: state advances, no check for that bit, no error pulse.
REQ-028 ACK_SLOT: evaluated 0 -> ackOk; evaluated 1 -> ackError, next state IDLE.
REQ-029 CRC_DEL, ACK_DEL, EOF0-EOF6 evaluated 0 -> bitError, next state IDLE.
REQ-030 IFS0 or IFS1 evaluated 0 -> overload, next state IDLE, no tailDone.
REQ-031 IFS2 evaluated 0 is a foreign start-of-frame, not an error; sequence continues normally.
REQ-032 tailDone SHALL pulse in the cycle IFS2 -> IDLE is taken on bitStart.
REQ-033 Error and evaluation cycle coincident with bitStart: error handling wins (IDLE, pulse asserted, no advance).
REQ-034 start in the same cycle as an abort to IDLE SHALL be ignored.
REQ-035 All pulse outputs SHALL be registered and high for exactly one cycle.
REQ-036 At most one of ackOk/ackError/bitError/overload/tailDone per cycle.

Reset
REQ-037 reset SHALL force IDLE, clear sample counter and sample registers, and hold them while asserted.
REQ-038 During reset: txOut=1, busy=0, all pulse outputs 0.
REQ-039 reset mid-sequence SHALL abort without any pulse.
REQ-040 First start is accepted in the first cycle after reset deasserts.

Verification
REQ-041 rateSelector=1, rxIn=1 except 0 during ACK_SLOT, 13 bitStarts -> ackOk once; tailDone after 13th bitStart; busy high for 13 bits.
REQ-042 rxIn=1 throughout the ACK slot -> ackError pulse; busy falls; no tailDone.
REQ-043 rateSelector=1, EOF3 samples 1,0,0 -> bitError, IDLE. Separately, EOF3 samples 0,1,1 -> no error, sequence completes.
REQ-044 rateSelector=0, rxIn=0 at IFS1 -> overload, no tailDone. Separately, rxIn=0 at IFS2 -> tailDone, no error.
REQ-045 reset asserted during EOF2 -> txOut=1, busy=0 next cycle, no pulses; later start gives a full 13-bit sequence.
REQ-046 start pulsed while busy, and 4 samplePulses in one bit -> both ignored; counts and results unchanged.

Source files
------------

// File: rtl/frame_tail_tx.sv
// Frame tail transmitter: walks CRC delimiter, ACK slot/delimiter, EOF and intermission
// while always driving recessive, and checks the read-back bus level once per bit.
module frame_tail_tx (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bitStart,
    input  logic samplePulse,
    input  logic rateSelector,
    input  logic rxIn,
    output logic txOut,
    output logic busy,
    output logic ackOk,
    output logic ackError,
    output logic bitError,
    output logic overload,
    output logic tailDone
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CRC_DEL  = 3'd1,
        ACK_SLOT = 3'd2,
        ACK_DEL  = 3'd3,
        EOF      = 3'd4,
        IFS      = 3'd5
    } state_t;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nxt;
    logic [1:0] r_samp_cnt;
    logic [2:0] r_samp;
    logic       r_eval;
    logic [1:0] w_samp_need;
    logic       w_capture;
    logic       w_bit_val;
    logic       w_dom_err;
    logic       w_ack_ok;
    logic       w_ack_err;
    logic       w_bit_err;
    logic       w_ovl;
    logic       w_done;

    assign w_samp_need = rateSelector ? 2'd3 : 2'd1;
    // A bit boundary takes priority over a coincident sample; surplus pulses fall through.
    assign w_capture   = samplePulse && !bitStart && (r_state != IDLE) && (r_samp_cnt < w_samp_need);
    assign w_bit_val   = rateSelector ? majority3(r_samp) : r_samp[0];
    assign w_dom_err   = r_eval && !w_bit_val;

    // Sample sequencer: captures up to the required samples and flags a one-shot evaluation.
    always_ff @(posedge clk) begin
        if (reset || bitStart || (r_state == IDLE)) begin
            r_samp_cnt <= 2'd0;
            r_samp     <= 3'b000;
            r_eval     <= 1'b0;
        end else begin
            r_eval <= w_capture && ((r_samp_cnt + 2'd1) == w_samp_need);
            if (w_capture) begin
                r_samp[r_samp_cnt] <= rxIn;
                r_samp_cnt         <= r_samp_cnt + 2'd1;
            end else begin
                r_samp_cnt <= r_samp_cnt;
            end
        end
    end

    // Next-state and pulse decode; an evaluated error always beats a coincident bit boundary.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_ack_ok      = 1'b0;
        w_ack_err     = 1'b0;
        w_bit_err     = 1'b0;
        w_ovl         = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt   = CRC_DEL;
                    w_bit_cnt_nxt = 3'd0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CRC_DEL: begin
                if (w_dom_err) begin
                    w_bit_err   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (bitStart) begin
                    w_state_nxt = ACK_SLOT;
                end else begin
                    w_state_nxt = CRC_DEL;
                end
            end
            ACK_SLOT: begin
                if (r_eval && w_bit_val) begin
                    w_ack_err   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_ack_ok    = r_eval;
                    w_state_nxt = bitStart ? ACK_DEL : ACK_SLOT;
                end
            end
            ACK_DEL: begin
                if (w_dom_err) begin
                    w_bit_err   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (bitStart) begin
                    w_state_nxt   = EOF;
                    w_bit_cnt_nxt = 3'd0;
                end else begin
                    w_state_nxt = ACK_DEL;
                end
            end
            EOF: begin
                if (w_dom_err) begin
                    w_bit_err   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (bitStart) begin
                    if (r_bit_cnt == 3'd6) begin
                        w_state_nxt   = IFS;
                        w_bit_cnt_nxt = 3'd0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_state_nxt = EOF;
                end
            end
            IFS: begin
                // Dominant in the last intermission bit is someone else's SOF, not an error.
                if (w_dom_err && (r_bit_cnt != 3'd2)) begin
                    w_ovl       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (bitStart) begin
                    if (r_bit_cnt == 3'd2) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_state_nxt = IFS;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_bit_cnt_nxt = 3'd0;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            txOut     <= 1'b1;
            busy      <= 1'b0;
            ackOk     <= 1'b0;
            ackError  <= 1'b0;
            bitError  <= 1'b0;
            overload  <= 1'b0;
            tailDone  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            txOut     <= 1'b1;
            busy      <= (w_state_nxt != IDLE);
            ackOk     <= w_ack_ok;
            ackError  <= w_ack_err;
            bitError  <= w_bit_err;
            overload  <= w_ovl;
            tailDone  <= w_done;
        end
    end

endmodule

// File: tb/tb_frame_tail_tx.sv
// Scoreboard bench for frame_tail_tx: expected pulses queued per bit, matched by a monitor.
module tb_frame_tail_tx;

    logic clk = 1'b0;
    logic reset, start, bitStart, samplePulse, rateSelector, rxIn;
    logic txOut, busy, ackOk, ackError, bitError, overload, tailDone;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    logic [2:0] pat [13];
    int nsamp [13];
    int reset_at;
    bit inject_start;
    int m_cnt, m_code, m_exp;

    frame_tail_tx dut (
        .clk(clk), .reset(reset), .start(start), .bitStart(bitStart),
        .samplePulse(samplePulse), .rateSelector(rateSelector), .rxIn(rxIn),
        .txOut(txOut), .busy(busy), .ackOk(ackOk), .ackError(ackError),
        .bitError(bitError), .overload(overload), .tailDone(tailDone)
    );

    always #5 clk = ~clk;

    // Codes: 1 ackOk, 2 ackError, 3 bitError, 4 overload, 5 tailDone
    always @(negedge clk) begin
        total++;
        if (txOut !== 1'b1) begin
            bad++;
            $display("FAIL txOut_recessive: got %b want 1 at %0t", txOut, $time);
        end
        m_cnt = $countones({ackOk, ackError, bitError, overload, tailDone});
        if (m_cnt > 1) begin
            total++;
            bad++;
            $display("FAIL pulse_exclusive: %0d pulses high, want at most 1 at %0t", m_cnt, $time);
        end else if (m_cnt == 1) begin
            m_code = ackOk ? 1 : ackError ? 2 : bitError ? 3 : overload ? 4 : 5;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got code %0d want none at %0t", m_code, $time);
            end else begin
                m_exp = exp_q.pop_front();
                if (m_code !== m_exp) begin
                    bad++;
                    $display("FAIL pulse_code: got %0d want %0d at %0t", m_code, m_exp, $time);
                end
            end
        end
    end

    task automatic set_defaults(input logic rate);
        rateSelector = rate;
        for (int b = 0; b < 13; b++) begin
            pat[b]   = 3'b111;
            nsamp[b] = rate ? 3 : 1;
        end
        pat[1]       = 3'b000;
        reset_at     = -1;
        inject_start = 1'b0;
    endtask

    task automatic drive_bit(input int b);
        @(negedge clk);
        if (b == 0) start = 1'b1;
        else        bitStart = 1'b1;
        rxIn = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        bitStart = 1'b0;
        if (reset_at == b) begin
            reset = 1'b1;
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || txOut !== 1'b1) begin
                bad++;
                $display("FAIL reset_mid: busy=%b txOut=%b want busy=0 txOut=1", busy, txOut);
            end
            reset = 1'b0;
        end
        for (int i = 0; i < nsamp[b]; i++) begin
            rxIn        = (i < 3) ? pat[b][i] : 1'b0;
            samplePulse = 1'b1;
            if (inject_start && i == 1) start = 1'b1;
            @(negedge clk);
            samplePulse = 1'b0;
            start       = 1'b0;
            rxIn        = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input string name);
        bit   aborted = 1'b0;
        logic v;
        int   need = rateSelector ? 3 : 1;
        for (int b = 0; b < 13; b++) begin
            if (!aborted && b == reset_at) begin
                aborted = 1'b1;
            end else if (!aborted && nsamp[b] >= need) begin
                v = rateSelector ? ($countones(pat[b]) >= 2) : pat[b][0];
                if (b == 1) begin
                    if (v) begin exp_q.push_back(2); aborted = 1'b1; end
                    else   exp_q.push_back(1);
                end else if (b <= 9 && !v) begin
                    exp_q.push_back(3); aborted = 1'b1;
                end else if ((b == 10 || b == 11) && !v) begin
                    exp_q.push_back(4); aborted = 1'b1;
                end
            end
            drive_bit(b);
            total++;
            if (busy !== logic'(!aborted)) begin
                bad++;
                $display("FAIL %s_busy_bit%0d: got %b want %b", name, b, busy, !aborted);
            end
        end
        if (!aborted) exp_q.push_back(5);
        @(negedge clk);
        bitStart = 1'b1;
        @(negedge clk);
        bitStart = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: %0d expected pulses not seen, want 0", name, exp_q.size());
        end
        exp_q.delete();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_end: got %b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start    = 1'b1;
            bitStart = i[0];
            @(negedge clk);
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy: got %b want 0", busy);
            end
        end
        reset    = 1'b0;
        start    = 1'b1;
        bitStart = 1'b0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL first_start: busy got %b want 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: busy got %b want 0", busy);
        end
    endtask

    task automatic test_nominal();
        set_defaults(1'b1);
        run_frame("nominal");
    endtask

    task automatic test_ack_error();
        set_defaults(1'b1);
        pat[1] = 3'b111;
        run_frame("ack_error");
    endtask

    task automatic test_majority();
        set_defaults(1'b1);
        pat[6] = 3'b001;
        run_frame("eof3_100");
        set_defaults(1'b1);
        pat[6] = 3'b110;
        run_frame("eof3_011");
    endtask

    task automatic test_single_sample();
        set_defaults(1'b0);
        pat[11] = 3'b000;
        run_frame("ifs1_dom");
        set_defaults(1'b0);
        pat[12] = 3'b000;
        run_frame("ifs2_sof");
        set_defaults(1'b0);
        pat[0] = 3'b000;
        run_frame("crc_del_dom");
    endtask

    task automatic test_reset_mid();
        set_defaults(1'b1);
        reset_at = 5;
        run_frame("reset_eof2");
        set_defaults(1'b1);
        run_frame("after_reset");
    endtask

    task automatic test_ignored_inputs();
        set_defaults(1'b0);
        nsamp[4]     = 4;
        pat[4]       = 3'b001;
        inject_start = 1'b1;
        run_frame("extra_pulses");
    endtask

    task automatic test_early_bitstart();
        set_defaults(1'b1);
        nsamp[3] = 2;
        pat[3]   = 3'b000;
        run_frame("early_bitstart");
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bitStart     = 1'b0;
        samplePulse  = 1'b0;
        rateSelector = 1'b1;
        rxIn         = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_nominal();
        test_ack_error();
        test_majority();
        test_single_sample();
        test_reset_mid();
        test_ignored_inputs();
        test_early_bitstart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
